// File: rtl/hdmi_pkg.sv
// Shared definitions for the HDMI channel deskew block: FSM encoding,
// default skew range and the width helpers used by the top and the delay taps.
package hdmi_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam int MAX_SKEW_DEFAULT = 4;

    // One spare bit above what max_skew needs, so the counter can step past the
    // limit and the overflow is visible without wrapping.
    function automatic int cnt_width(input int max_skew);
        return $clog2(max_skew + 1) + 1;
    endfunction

    function automatic int tap_width(input int max_skew);
        return $clog2(max_skew + 1);
    endfunction

endpackage

// File: rtl/hdmi_delay_tap.sv
// Per-channel variable delay: {de, word} leaves exactly 1 + i_tap clocks after it
// entered. G_MAX_SKEW shift stages plus the output register give G_MAX_SKEW+1 stages.
module hdmi_delay_tap
    import hdmi_pkg::*;
#(
    parameter int  G_WIDTH    = 10,
    parameter int  G_MAX_SKEW = MAX_SKEW_DEFAULT,
    localparam int TW         = tap_width(G_MAX_SKEW)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [G_WIDTH:0] i_word,
    input  logic [TW-1:0]    i_tap,
    output logic [G_WIDTH:0] o_word
);

    logic [G_WIDTH:0] sr_q [G_MAX_SKEW];
    logic [G_WIDTH:0] sr_d [G_MAX_SKEW];
    logic [G_WIDTH:0] out_q;
    logic [G_WIDTH:0] out_d;

    always_comb begin
        sr_d[0] = i_word;
        for (int i = 1; i < G_MAX_SKEW; i++) begin
            sr_d[i] = sr_q[i-1];
        end
        // NOTE: out_d gets a default before the tap search so no path leaves it
        // unassigned; otherwise synthesis would infer a latch.
        out_d = i_word;
        for (int i = 0; i < G_MAX_SKEW; i++) begin
            if (i_tap == TW'(i + 1)) begin
                out_d = sr_q[i];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: the delay line is deliberately reset, stage by stage, so a stale
            // data-enable cannot leak out after reset and fake an alignment event.
            for (int i = 0; i < G_MAX_SKEW; i++) begin
                sr_q[i] <= '0;
            end
            out_q <= '0;
        end else begin
            // NOTE: non-blocking assignments let every stage sample its predecessor's
            // old value, which is what makes this a shift register.
            sr_q  <= sr_d;
            out_q <= out_d;
        end
    end

    assign o_word = out_q;

endmodule

// File: rtl/hdmi_channel_deskew.sv
// Aligns the three decoded TMDS channels by timing the first data-enable rising
// edge on each, then delaying the early channels to match the latest one.
module hdmi_channel_deskew
    import hdmi_pkg::*;
#(
    parameter int G_WIDTH    = 10,
    parameter int G_MAX_SKEW = MAX_SKEW_DEFAULT
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [G_WIDTH-1:0] i_d0,
    input  logic [G_WIDTH-1:0] i_d1,
    input  logic [G_WIDTH-1:0] i_d2,
    input  logic               i_de0,
    input  logic               i_de1,
    input  logic               i_de2,
    input  logic               i_enable,
    output logic [G_WIDTH-1:0] o_q0,
    output logic [G_WIDTH-1:0] o_q1,
    output logic [G_WIDTH-1:0] o_q2,
    output logic               o_de,
    output logic               o_locked,
    output logic               o_err
);

    localparam int            CW        = cnt_width(G_MAX_SKEW);
    localparam int            TW        = tap_width(G_MAX_SKEW);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(G_MAX_SKEW);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_inc, arr_max;
    logic [CW-1:0]    arr_q [3];
    logic [CW-1:0]    arr_d [3];
    logic [TW-1:0]    tap_q [3];
    logic [TW-1:0]    tap_d [3];
    logic [2:0]       rec_q, rec_d;
    logic [2:0]       de_prev_q, de_raw, rise;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic             go_search;
    logic [G_WIDTH:0] word_in  [3];
    logic [G_WIDTH:0] word_out [3];
    logic [2:0]       de_al;
    logic             de_mismatch;

    assign word_in[0] = {i_de0, i_d0};
    assign word_in[1] = {i_de1, i_d1};
    assign word_in[2] = {i_de2, i_d2};
    assign de_raw     = {i_de2, i_de1, i_de0};
    assign rise       = de_raw & ~de_prev_q;

    for (genvar k = 0; k < 3; k++) begin : g_lane
        hdmi_delay_tap #(
            .G_WIDTH    (G_WIDTH),
            .G_MAX_SKEW (G_MAX_SKEW)
        ) u_tap (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_word  (word_in[k]),
            .i_tap   (tap_q[k]),
            .o_word  (word_out[k])
        );
        assign de_al[k] = word_out[k][G_WIDTH];
    end

    assign de_mismatch = (|de_al) && !(&de_al);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        arr_d     = arr_q;
        rec_d     = rec_q;
        tap_d     = tap_q;
        err_d     = 1'b0;
        go_search = 1'b0;
        locked_d  = (state_q == ST_LOCKED);
        cnt_inc   = cnt_q + 1'b1;
        arr_max   = arr_q[0];
        for (int k = 1; k < 3; k++) begin
            if (arr_q[k] > arr_max) arr_max = arr_q[k];
        end

        if (!i_enable) begin
            go_search = 1'b1;
        end else begin
            case (state_q)
                ST_SEARCH: begin
                    if (|rise) begin
                        state_d = ST_MEASURE;
                        cnt_d   = '0;
                        rec_d   = rise;
                        for (int k = 0; k < 3; k++) arr_d[k] = '0;
                    end
                end
                ST_MEASURE: begin
                    if (&rec_q) begin
                        state_d = ST_LOCKED;
                        for (int k = 0; k < 3; k++) tap_d[k] = TW'(arr_max - arr_q[k]);
                    end else if (cnt_inc > CNT_LIMIT) begin
                        err_d     = 1'b1;
                        go_search = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                        for (int k = 0; k < 3; k++) begin
                            if (rise[k] && !rec_q[k]) begin
                                rec_d[k] = 1'b1;
                                arr_d[k] = cnt_inc;
                            end
                        end
                    end
                end
                ST_LOCKED: begin
                    // locked_q gates the check so the first LOCKED clock, whose outputs
                    // were still produced by the old taps, cannot trip a false mismatch.
                    if (locked_q && de_mismatch) begin
                        err_d     = 1'b1;
                        go_search = 1'b1;
                    end
                end
                default: go_search = 1'b1;
            endcase
        end

        if (go_search) begin
            state_d = ST_SEARCH;
            cnt_d   = '0;
            rec_d   = '0;
            for (int k = 0; k < 3; k++) begin
                arr_d[k] = '0;
                tap_d[k] = '0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_SEARCH;
            cnt_q     <= '0;
            rec_q     <= '0;
            de_prev_q <= '0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                arr_q[k] <= '0;
                tap_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rec_q     <= rec_d;
            de_prev_q <= de_raw;
            locked_q  <= locked_d;
            err_q     <= err_d;
            arr_q     <= arr_d;
            tap_q     <= tap_d;
        end
    end

    assign o_q0     = word_out[0][G_WIDTH-1:0];
    assign o_q1     = word_out[1][G_WIDTH-1:0];
    assign o_q2     = word_out[2][G_WIDTH-1:0];
    assign o_de     = de_al[0];
    assign o_locked = locked_q;
    assign o_err    = err_q;

endmodule
